// File: rtl/serial_receiver_n_bits_pkg.sv
// Shared types and constants for the N-bit serial frame receiver.
// Holds the FSM state encoding and the legal WIDTH range.
package serial_receiver_n_bits_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

// File: rtl/serial_receiver_n_bits.sv
// MSB-first serial frame receiver with a one-deep output holding register,
// valid/ready handoff and a sticky overrun flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for START; ENABLE and IN are ignored
// ST_RECV | shifting in bits on ENABLE strobes until WIDTH bits are seen
module serial_receiver_n_bits
    import serial_receiver_n_bits_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             START,
    input  logic             IN,
    input  logic             READY,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVERRUN
);

    localparam int CW = $clog2(WIDTH + 1);
    // The last bit never lands in the shift register: on the completing
    // strobe it goes straight into the holding register with the rest.
    localparam int SW = WIDTH - 1;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_receiver_n_bits: WIDTH out of legal range");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    sh_q, sh_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             complete;
    logic             ovr_set;
    logic [WIDTH-1:0] word;

    assign word = {sh_q, IN};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // START wins over everything, including a completion on the same edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        complete = 1'b0;

        if (START) begin
            state_d = ST_RECV;
            if (ENABLE) begin
                sh_d  = SW'(word);
                cnt_d = CW'(1);
            end else begin
                cnt_d = '0;
            end
        end else if (state_q == ST_RECV && ENABLE) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
                complete = 1'b1;
                state_d  = ST_IDLE;
                cnt_d    = '0;
            end else begin
                sh_d  = SW'(word);
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Output holding register: a new word is only accepted if the slot is
    // empty or being drained on this very edge; otherwise it is dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_set = 1'b0;

        if (complete) begin
            if (!valid_q || READY) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (CLEAR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign BUSY    = (state_q == ST_RECV);
    assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_serial_receiver_n_bits.sv
// Self-checking bench for serial_receiver_n_bits (WIDTH=16): expected words
// are queued when a frame is sent and compared when the consumer accepts one.
module tb_serial_receiver_n_bits;

    localparam int W = 16;

    logic         CLK;
    logic         RESET_N;
    logic         ENABLE;
    logic         START;
    logic         IN;
    logic         READY;
    logic         CLEAR;
    logic [W-1:0] DATA;
    logic         VALID;
    logic         BUSY;
    logic         OVERRUN;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic         mon_en = 1'b0;

    serial_receiver_n_bits #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .ENABLE  (ENABLE),
        .START   (START),
        .IN      (IN),
        .READY   (READY),
        .CLEAR   (CLEAR),
        .DATA    (DATA),
        .VALID   (VALID),
        .BUSY    (BUSY),
        .OVERRUN (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge consume them, return 1 time unit
    // after the edge with strobes released.
    task automatic cyc(input logic s, input logic e, input logic i);
        START  = s;
        ENABLE = e;
        IN     = i;
        @(posedge CLK);
        #1;
        START  = 1'b0;
        ENABLE = 1'b0;
        IN     = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input int gap, input logic rdy_last);
        cyc(1'b1, 1'b1, word[W-1]);
        for (int i = W - 2; i >= 0; i--) begin
            repeat (gap) cyc(1'b0, 1'b0, 1'b0);
            if (i == 0 && rdy_last) READY = 1'b1;
            cyc(1'b0, 1'b1, word[i]);
        end
    endtask

    // Consumer side: a handshake happens on the next edge whenever both are high.
    always @(negedge CLK) begin
        if (mon_en && VALID && READY) begin
            if (exp_q.size() == 0) chk("sb_underflow", 64'(DATA), 64'hDEAD);
            else chk("sb_data", 64'(DATA), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        int vcount;
        logic [W-1:0] partial;

        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        START   = 1'b0;
        IN      = 1'b0;
        READY   = 1'b0;
        CLEAR   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_data", 64'(DATA), 64'h0);
        chk("rst_valid", 64'(VALID), 64'h0);
        chk("rst_busy", 64'(BUSY), 64'h0);
        chk("rst_overrun", 64'(OVERRUN), 64'h0);
        RESET_N = 1'b1;
        mon_en  = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("idle_ignores_enable", 64'(BUSY), 64'h0);

        // Basic frame, back-to-back strobes
        exp_q.push_back(16'hA5C3);
        send_frame(16'hA5C3, 0, 1'b0);
        chk("basic_valid", 64'(VALID), 64'h1);
        chk("basic_data", 64'(DATA), 64'hA5C3);
        chk("basic_busy", 64'(BUSY), 64'h0);
        READY = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("basic_drained", 64'(VALID), 64'h0);

        // Sparse strobes, consumer always ready
        exp_q.push_back(16'hA5C3);
        send_frame(16'hA5C3, 2, 1'b0);
        vcount = 0;
        for (int k = 0; k < 5; k++) begin
            if (VALID) vcount++;
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk("sparse_valid_cycles", 64'(vcount), 64'd1);

        // Overrun: pending 0x1234 is kept, 0xFFFF is dropped
        READY = 1'b0;
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, 0, 1'b0);
        chk("ovr_first_valid", 64'(VALID), 64'h1);
        send_frame(16'hFFFF, 1, 1'b0);
        chk("ovr_data_held", 64'(DATA), 64'h1234);
        chk("ovr_flag", 64'(OVERRUN), 64'h1);
        chk("ovr_valid_held", 64'(VALID), 64'h1);
        CLEAR = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        CLEAR = 1'b0;
        chk("clear_overrun", 64'(OVERRUN), 64'h0);

        // CLEAR held across a second dropped frame: set wins, then clears
        CLEAR = 1'b1;
        send_frame(16'h0F0F, 0, 1'b0);
        chk("clear_vs_set", 64'(OVERRUN), 64'h1);
        chk("clear_vs_set_data", 64'(DATA), 64'h1234);
        cyc(1'b0, 1'b0, 1'b0);
        CLEAR = 1'b0;
        chk("clear_after_set", 64'(OVERRUN), 64'h0);

        // Drain and refill on the same edge
        exp_q.push_back(16'h00FF);
        send_frame(16'h00FF, 0, 1'b1);
        chk("swap_data", 64'(DATA), 64'h00FF);
        chk("swap_valid", 64'(VALID), 64'h1);
        chk("swap_overrun", 64'(OVERRUN), 64'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("swap_drained", 64'(VALID), 64'h0);

        // Abort after 7 bits, then a full frame
        partial = 16'hFE00;
        cyc(1'b1, 1'b1, partial[W-1]);
        for (int i = W - 2; i >= W - 7; i--) cyc(1'b0, 1'b1, partial[i]);
        chk("partial_busy", 64'(BUSY), 64'h1);
        chk("partial_no_valid", 64'(VALID), 64'h0);
        exp_q.push_back(16'h8001);
        send_frame(16'h8001, 0, 1'b0);
        chk("abort_data", 64'(DATA), 64'h8001);
        cyc(1'b0, 1'b0, 1'b0);

        // Reset mid-frame after 9 bits
        READY = 1'b0;
        exp_q.push_back(16'h5A5A);
        send_frame(16'h5A5A, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'(i));
        #1 RESET_N = 1'b0;
        #1;
        chk("arst_data", 64'(DATA), 64'h0);
        chk("arst_valid", 64'(VALID), 64'h0);
        chk("arst_busy", 64'(BUSY), 64'h0);
        chk("arst_overrun", 64'(OVERRUN), 64'h0);
        void'(exp_q.pop_back());
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        READY = 1'b1;
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b1, 1'(k));
            if (VALID || BUSY) vcount++;
        end
        chk("post_rst_silent", 64'(vcount), 64'd0);
        exp_q.push_back(16'h3C96);
        send_frame(16'h3C96, 0, 1'b0);
        chk("post_rst_frame", 64'(DATA), 64'h3C96);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
